// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the MEM/WB stage: datapath width, writeback
// source selector and load funct3 encodings.
`timescale 1ns/1ps
package riscv_pkg;

  localparam int XLEN = 32;

  // Writeback value source; the reserved encoding falls back to the ALU value.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: the MEM-stage result bundle going in and the register
// file write port coming out. The master is the MEM side, the slave is the
// MEM/WB stage itself.
`timescale 1ns/1ps
interface mem_wb_stage_if;
  import riscv_pkg::*;

  // MEM-stage results
  logic              in_valid;
  logic              in_reg_write;
  logic [4:0]        in_rd;
  result_src_e       in_result_src;
  logic [2:0]        in_funct3;
  logic [XLEN-1:0]   in_alu_result;
  logic [XLEN-1:0]   in_mem_rdata;
  logic [XLEN-1:0]   in_pc_plus4;

  // Register file write port and WB occupancy
  logic              we;
  logic [4:0]        rd;
  logic [XLEN-1:0]   wd;
  logic              wb_valid;

  modport master (
    output in_valid, in_reg_write, in_rd, in_result_src, in_funct3,
           in_alu_result, in_mem_rdata, in_pc_plus4,
    input  we, rd, wd, wb_valid
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_result_src, in_funct3,
           in_alu_result, in_mem_rdata, in_pc_plus4,
    output we, rd, wd, wb_valid
  );

endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load data extraction: picks the addressed byte/half out of the aligned
// memory word and sign- or zero-extends it. Purely combinational.
`timescale 1ns/1ps
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half; off[0] is ignored for halves (no misalign trap)
  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend according to load type; undefined encodings pass the raw word
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback for the RV32I core. Captures the
// MEM-stage results, extracts/extends load data and drives the register file
// write port directly from the stage register.
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_count output,
// a free-running count of instructions leaving the WB stage.
`timescale 1ns/1ps
module mem_wb_stage #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic           flush,
  mem_wb_stage_if.slave  bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] retire_count
`endif
);
  import riscv_pkg::*;

  logic              valid_q;
  logic              reg_write_q;
  logic [4:0]        rd_q;
  result_src_e       result_src_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   alu_result_q;
  logic [XLEN-1:0]   mem_rdata_q;
  logic [XLEN-1:0]   pc_plus4_q;
  logic [XLEN-1:0]   load_data;
  logic              retire;

  // Stage register: flush inserts a bubble (and wins over stall), stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= RES_ALU;
      funct3_q     <= '0;
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_plus4_q   <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q      <= bus.in_valid;
      reg_write_q  <= bus.in_reg_write;
      rd_q         <= bus.in_rd;
      result_src_q <= bus.in_result_src;
      funct3_q     <= bus.in_funct3;
      alu_result_q <= bus.in_alu_result;
      mem_rdata_q  <= bus.in_mem_rdata;
      pc_plus4_q   <= bus.in_pc_plus4;
    end
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata_q),
    .off    (alu_result_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Writeback mux and register file write port; x0 is never written
  always_comb begin
    bus.wd = alu_result_q;
    case (result_src_q)
      RES_LOAD: bus.wd = load_data;
      RES_PC4:  bus.wd = pc_plus4_q;
      default:  bus.wd = alu_result_q;
    endcase
    bus.we       = valid_q & reg_write_q & (rd_q != 5'd0);
    bus.rd       = rd_q;
    bus.wb_valid = valid_q;
  end

  // The instruction in WB leaves on any edge where it is not held by a stall
  assign retire = valid_q & (flush | ~stall);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign retire_count = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire ^ (CNT_WIDTH != 0);
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors push their hand-computed
// writeback into a scoreboard queue; a monitor pops and compares after
// every rising edge. Define WB_RETIRE_CNT_EN to also cover retire_count.
`timescale 1ns/1ps
module tb_mem_wb_stage;
  import riscv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.XLEN(32), .CNT_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        valid;
    logic        chk_data;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cnt = '0;
  logic        last_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT output with the oldest expectation 2ns after each edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("wb_valid", 64'(bus.wb_valid), 64'(e.valid));
      check("we", 64'(bus.we), 64'(e.we));
      if (e.chk_data) begin
        check("rd", 64'(bus.rd), 64'(e.rd));
        check("wd", 64'(bus.wd), 64'(e.wd));
      end
`ifdef WB_RETIRE_CNT_EN
      check("retire_count", retire_count, e.cnt);
`endif
    end
  end

  // Apply one cycle of stimulus (caller is just after a negedge) and queue the result
  task automatic step(input logic v, input logic rw, input logic [4:0] r,
                      input logic [1:0] src, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                      input logic st, input logic fl,
                      input logic ewe, input logic [4:0] erd, input logic [31:0] ewd,
                      input logic evalid, input logic echk);
    exp_t e;
    rst_n                 = 1'b1;
    bus.in_valid          = v;
    bus.in_reg_write      = rw;
    bus.in_rd             = r;
    bus.in_result_src     = result_src_e'(src);
    bus.in_funct3         = f3;
    bus.in_alu_result     = alu;
    bus.in_mem_rdata      = rdata;
    bus.in_pc_plus4       = pc4;
    stall                 = st;
    flush                 = fl;
    if (last_valid && (fl || !st)) exp_cnt = exp_cnt + 64'd1;
    e.we       = ewe;
    e.rd       = erd;
    e.wd       = ewd;
    e.valid    = evalid;
    e.chk_data = echk;
    e.cnt      = exp_cnt;
    sb.push_back(e);
    last_valid = evalid;
    @(negedge clk);
  endtask

  // Hold reset for one cycle with idle inputs; everything reads as zero
  task automatic reset_step();
    exp_t e;
    rst_n                 = 1'b0;
    bus.in_valid          = 1'b0;
    bus.in_reg_write      = 1'b0;
    bus.in_rd             = '0;
    bus.in_result_src     = RES_ALU;
    bus.in_funct3         = '0;
    bus.in_alu_result     = '0;
    bus.in_mem_rdata      = '0;
    bus.in_pc_plus4       = '0;
    stall                 = 1'b0;
    flush                 = 1'b0;
    exp_cnt               = '0;
    last_valid            = 1'b0;
    e.we = 1'b0; e.rd = '0; e.wd = '0; e.valid = 1'b0; e.chk_data = 1'b1; e.cnt = '0;
    sb.push_back(e);
    @(negedge clk);
  endtask

  localparam logic [31:0] RD_WORD = 32'h80F0_7F81;

  initial begin
    @(negedge clk);
    // Reset and idle release
    reset_step();
    step(0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0, 0,0, 0,0,32'h0,0,1);

    // ALU writeback, then the same to x0
    step(1,1,5,2'b00,3'b000,32'h1234_5678,32'h0,32'h0, 0,0, 1,5,32'h1234_5678,1,1);
    step(1,1,0,2'b00,3'b000,32'h1234_5678,32'h0,32'h0, 0,0, 0,0,32'h1234_5678,1,1);

    // Loads from 0x80F0_7F81 at every offset of interest
    step(1,1,7,2'b01,F3_LB, 32'h100,RD_WORD,32'h0, 0,0, 1,7,32'hFFFF_FF81,1,1);
    step(1,1,7,2'b01,F3_LB, 32'h101,RD_WORD,32'h0, 0,0, 1,7,32'h0000_007F,1,1);
    step(1,1,7,2'b01,F3_LB, 32'h102,RD_WORD,32'h0, 0,0, 1,7,32'hFFFF_FFF0,1,1);
    step(1,1,7,2'b01,F3_LBU,32'h103,RD_WORD,32'h0, 0,0, 1,7,32'h0000_0080,1,1);
    step(1,1,7,2'b01,F3_LH, 32'h102,RD_WORD,32'h0, 0,0, 1,7,32'hFFFF_80F0,1,1);
    step(1,1,7,2'b01,F3_LH, 32'h103,RD_WORD,32'h0, 0,0, 1,7,32'hFFFF_80F0,1,1);
    step(1,1,7,2'b01,F3_LHU,32'h100,RD_WORD,32'h0, 0,0, 1,7,32'h0000_7F81,1,1);
    step(1,1,7,2'b01,F3_LHU,32'h101,RD_WORD,32'h0, 0,0, 1,7,32'h0000_7F81,1,1);
    step(1,1,7,2'b01,F3_LW, 32'h101,RD_WORD,32'h0, 0,0, 1,7,32'h80F0_7F81,1,1);
    step(1,1,7,2'b01,3'b011,32'h102,RD_WORD,32'h0, 0,0, 1,7,32'h80F0_7F81,1,1);

    // PC+4 link value, reserved source treated as ALU, reg_write=0
    step(1,1,1,2'b10,3'b000,32'hDEAD,32'h0,32'h404, 0,0, 1,1,32'h0000_0404,1,1);
    step(1,1,1,2'b11,3'b000,32'hDEAD,32'h0,32'h404, 0,0, 1,1,32'h0000_DEAD,1,1);
    step(1,0,4,2'b00,3'b000,32'h55,  32'h0,32'h0,   0,0, 0,4,32'h0000_0055,1,1);

    // Stall for 3 cycles with a new input pending; old value held, new one follows
    step(1,1,9, 2'b00,3'b000,32'hAAAA_0001,32'h0,32'h0, 0,0, 1,9,32'hAAAA_0001,1,1);
    for (int i = 0; i < 3; i++)
      step(1,1,10,2'b00,3'b000,32'hBBBB_0002,32'h0,32'h0, 1,0, 1,9,32'hAAAA_0001,1,1);
    step(1,1,10,2'b00,3'b000,32'hBBBB_0002,32'h0,32'h0, 0,0, 1,10,32'hBBBB_0002,1,1);

    // Flush with stall (WB valid -> retires), flush alone on a bubble, then capture
    step(1,1,11,2'b00,3'b000,32'hCCCC_0003,32'h0,32'h0, 1,1, 0,0,32'h0,0,0);
    step(1,1,11,2'b00,3'b000,32'hCCCC_0003,32'h0,32'h0, 0,1, 0,0,32'h0,0,0);
    step(1,1,11,2'b00,3'b000,32'hCCCC_0003,32'h0,32'h0, 0,0, 1,11,32'hCCCC_0003,1,1);

    // Reset mid-operation discards the instruction; no write after release
    reset_step();
    step(0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0, 0,0, 0,0,32'h0,0,1);

    // Ten valid instructions with two bubbles, starting from a cleared counter
    reset_step();
    step(0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0, 0,0, 0,0,32'h0,0,1);
    for (int i = 0; i < 12; i++) begin
      if (i == 3 || i == 7)
        step(0,1,5'(i+1),2'b00,3'b000,32'(i*16),32'h0,32'h0, 0,0, 0,5'(i+1),32'(i*16),0,1);
      else
        step(1,1,5'(i+1),2'b00,3'b000,32'(i*16),32'h0,32'h0, 0,0, 1,5'(i+1),32'(i*16),1,1);
    end
    step(0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0, 0,0, 0,0,32'h0,0,1);
`ifdef WB_RETIRE_CNT_EN
    #1;
    check("retire_count_after_10", retire_count, 64'd10);
    @(negedge clk);
`endif

    // Put a valid instruction in WB, then preload the counter just below wrap
    step(1,1,2,2'b00,3'b000,32'h1,32'h0,32'h0, 0,0, 1,2,32'h1,1,1);
`ifdef WB_RETIRE_CNT_EN
    force dut.cnt_q = '1;
    #1;
    release dut.cnt_q;
    #1;
    check("retire_count_preload", retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    step(0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0, 0,0, 0,0,32'h0,0,1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
